// File: rtl/pixel_decryptor_if.sv
// Stream bundle for pixel_decryptor: ciphertext and keystream in, plaintext out.
// The decryptor takes the slave modport; a source/sink takes the master modport.
interface pixel_decryptor_if #(
  parameter int PIX_W     = 8,
  parameter int PRECISION = 32
);
  logic                 c_valid;
  logic                 c_ready;
  logic [PIX_W-1:0]     c_data;
  logic                 k_valid;
  logic                 k_ready;
  logic [PRECISION-1:0] k_data;
  logic                 p_valid;
  logic                 p_ready;
  logic [PIX_W-1:0]     p_data;

  modport master (
    output c_valid, c_data, k_valid, k_data, p_ready,
    input  c_ready, k_ready, p_valid, p_data
  );

  modport slave (
    input  c_valid, c_data, k_valid, k_data, p_ready,
    output c_ready, k_ready, p_valid, p_data
  );
endinterface

// File: rtl/pixel_decryptor.sv
// Chaotic-keystream pixel decryptor; ciphertext and key words are consumed in lockstep.
// Optional feature macro: DEC_CHAIN_EN enables chaining on the previous ciphertext pixel.
module pixel_decryptor #(
  parameter int PIX_W     = 8,
  parameter int LEN_W     = 20,
  parameter int PRECISION = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PIX_W-1:0]  iv,
  input  logic [LEN_W-1:0]  frame_len,
  pixel_decryptor_if.slave  bus,
  output logic              busy,
  output logic              frame_done,
  output logic              key_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] remaining;
  logic             p_valid_q;
  logic [PIX_W-1:0] p_data_q;
  logic             key_err_q;
  logic             accept;
  logic             start_ok;
  logic [7:0]       key_byte;
  logic [PIX_W-1:0] key_ext;
  logic [PIX_W-1:0] plain;
  logic             key_nan;

  // Mantissa-only key: sign and exponent of the float word never reach the data path
  assign key_byte = bus.k_data[22:15] ^ bus.k_data[7:0];
  assign key_ext  = PIX_W'(key_byte);
  assign key_nan  = (bus.k_data[30:23] == 8'hFF);

  assign start_ok = (state == IDLE) && start;
  assign accept   = (state == RUN) && bus.c_valid && bus.k_valid &&
                    (remaining != '0) && (!p_valid_q || bus.p_ready);

`ifdef DEC_CHAIN_EN
  logic [PIX_W-1:0] chain_q;

  assign plain = bus.c_data - key_ext - chain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      chain_q <= '0;
    else if (start_ok)
      chain_q <= iv;
    else if (accept)
      chain_q <= bus.c_data;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.k_data[PRECISION-1:31], bus.k_data[14:8]};
`else
  assign plain = bus.c_data - key_ext;

  logic unused_bits;
  assign unused_bits = ^{iv, bus.k_data[PRECISION-1:31], bus.k_data[14:8]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (frame_len == '0) ? DONE : RUN;
      RUN:     if (accept && (remaining == LEN_W'(1))) state_next = FLUSH;
      FLUSH:   if (!p_valid_q || bus.p_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      key_err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        remaining <= frame_len;
        key_err_q <= 1'b0;
      end
      // A new pixel overwrites the output register in the same cycle the old one drains
      if (accept) begin
        remaining <= remaining - LEN_W'(1);
        p_valid_q <= 1'b1;
        p_data_q  <= plain;
        if (key_nan)
          key_err_q <= 1'b1;
      end else if (p_valid_q && bus.p_ready) begin
        p_valid_q <= 1'b0;
      end
    end
  end

  assign bus.c_ready = accept;
  assign bus.k_ready = accept;
  assign bus.p_valid = p_valid_q;
  assign bus.p_data  = p_data_q;
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);
  assign key_err     = key_err_q;

endmodule

// File: tb/tb_pixel_decryptor.sv
// Directed bench for pixel_decryptor: a vector table of whole frames plus
// hand-written sequences for stalls, missing keystream, key errors and reset.
module tb_pixel_decryptor;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  iv;
  logic [19:0] frame_len;
  logic        busy;
  logic        frame_done;
  logic        key_err;

  int errors = 0;
  int checks = 0;
  int out_count = 0;

  pixel_decryptor_if #(.PIX_W(8), .PRECISION(32)) bus ();

  pixel_decryptor #(.PIX_W(8), .LEN_W(20), .PRECISION(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .iv         (iv),
    .frame_len  (frame_len),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .key_err    (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.p_valid && bus.p_ready) out_count <= out_count + 1;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic        first;
    logic [7:0]  iv;
    logic [19:0] len;
    logic [7:0]  c;
    logic [31:0] k;
    logic [7:0]  p_chain;
    logic [7:0]  p_plain;
    logic        last;
  } vec_t;

  vec_t vecs[7];

  // Expected plaintext depends on whether the build chains on the previous pixel
  function automatic logic [7:0] sel(input logic [7:0] chained, input logic [7:0] plain);
`ifdef DEC_CHAIN_EN
    return chained;
`else
    return plain;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic startFrame(input logic [7:0] v, input logic [19:0] len);
    start = 1'b1;
    iv = v;
    frame_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [31:0] k, input string name);
    bus.c_valid = 1'b1;
    bus.k_valid = 1'b1;
    bus.c_data = c;
    bus.k_data = k;
    #1;
    checkOutput({name, " c_ready"}, 32'(bus.c_ready), 32'd1);
    @(negedge clk);
    bus.c_valid = 1'b0;
    bus.k_valid = 1'b0;
  endtask

  task automatic waitFrameDone(input string name);
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
    checkOutput({name, " frame_done pulses"}, 32'(pulses), 32'd1);
    checkOutput({name, " busy after frame"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;

    vecs[0] = '{1'b1, 8'h00, 20'd1, 8'h10, 32'h3F4A5C21, 8'h5B, 8'h5B, 1'b1};
    vecs[1] = '{1'b1, 8'h00, 20'd2, 8'h10, 32'h3F4A5C21, 8'h5B, 8'h5B, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 20'd2, 8'h20, 32'h00000000, 8'h10, 8'h20, 1'b1};
    vecs[3] = '{1'b1, 8'h37, 20'd4, 8'h80, 32'h00000003, 8'h46, 8'h7D, 1'b0};
    vecs[4] = '{1'b0, 8'h37, 20'd4, 8'h05, 32'h00008000, 8'h84, 8'h04, 1'b0};
    vecs[5] = '{1'b0, 8'h37, 20'd4, 8'hFF, 32'h007F80FF, 8'hFA, 8'hFF, 1'b0};
    vecs[6] = '{1'b0, 8'h37, 20'd4, 8'h00, 32'h000000AA, 8'h57, 8'h56, 1'b1};

    reset_n = 1'b0;
    start = 1'b0;
    iv = 8'h00;
    frame_len = '0;
    bus.c_valid = 1'b0;
    bus.k_valid = 1'b0;
    bus.c_data = 8'h00;
    bus.k_data = 32'h0;
    bus.p_ready = 1'b1;
    #2;
    checkOutput("reset p_valid", 32'(bus.p_valid), 32'd0);
    checkOutput("reset p_data", 32'(bus.p_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset key_err", 32'(key_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table frames with the output always ready
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].first) startFrame(vecs[i].iv, vecs[i].len);
      applyStimulus(vecs[i].c, vecs[i].k, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d p_valid", i), 32'(bus.p_valid), 32'd1);
      checkOutput($sformatf("vec%0d p_data", i), 32'(bus.p_data),
                  32'(sel(vecs[i].p_chain, vecs[i].p_plain)));
      if (vecs[i].last) waitFrameDone($sformatf("vec%0d", i));
    end

    // Output stall: held pixel stays put and both inputs are refused
    base = out_count;
    bus.p_ready = 1'b0;
    startFrame(8'h00, 20'd3);
    bus.c_valid = 1'b1;
    bus.k_valid = 1'b1;
    bus.c_data = 8'h11;
    bus.k_data = 32'h00000001;
    #1;
    checkOutput("stall first c_ready", 32'(bus.c_ready), 32'd1);
    @(negedge clk);
    bus.c_data = 8'h22;
    bus.k_data = 32'h00010000;
    start = 1'b1;
    frame_len = 20'd0;
    #1;
    checkOutput("stall k_ready low", 32'(bus.k_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("start in RUN ignored busy", 32'(busy), 32'd1);
    checkOutput("start in RUN ignored done", 32'(frame_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall p_data held", 32'(bus.p_data), 32'(sel(8'h10, 8'h10)));
      checkOutput("stall c_ready", 32'(bus.c_ready), 32'd0);
      checkOutput("stall k_ready", 32'(bus.k_ready), 32'd0);
    end
    bus.p_ready = 1'b1;
    #1;
    checkOutput("drain+accept c_ready", 32'(bus.c_ready), 32'd1);
    @(negedge clk);
    checkOutput("stall pix1 p_data", 32'(bus.p_data), 32'(sel(8'h0F, 8'h20)));
    bus.c_data = 8'h44;
    bus.k_data = 32'h00000000;
    #1;
    checkOutput("back-to-back c_ready", 32'(bus.c_ready), 32'd1);
    @(negedge clk);
    bus.c_valid = 1'b0;
    bus.k_valid = 1'b0;
    bus.p_ready = 1'b0;
    checkOutput("stall pix2 p_data", 32'(bus.p_data), 32'(sel(8'h22, 8'h44)));
    repeat (2) begin
      @(negedge clk);
      checkOutput("flush held no done", 32'(frame_done), 32'd0);
      checkOutput("flush held p_valid", 32'(bus.p_valid), 32'd1);
    end
    bus.p_ready = 1'b1;
    waitFrameDone("stall");
    checkOutput("stall output count", 32'(out_count - base), 32'd3);

    // Ciphertext waiting on a late keystream word
    startFrame(8'h10, 20'd1);
    bus.c_valid = 1'b1;
    bus.c_data = 8'h42;
    bus.k_data = 32'h00000002;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("no key c_ready", 32'(bus.c_ready), 32'd0);
      @(negedge clk);
      checkOutput("no key p_valid", 32'(bus.p_valid), 32'd0);
    end
    applyStimulus(8'h42, 32'h00000002, "late key");
    checkOutput("late key p_data", 32'(bus.p_data), 32'(sel(8'h30, 8'h40)));
    waitFrameDone("late key");

    // NaN keystream word sets the sticky error
    startFrame(8'h00, 20'd3);
    applyStimulus(8'h50, 32'h00000000, "nan pix0");
    checkOutput("nan pix0 key_err", 32'(key_err), 32'd0);
    checkOutput("nan pix0 p_data", 32'(bus.p_data), 32'(sel(8'h50, 8'h50)));
    applyStimulus(8'h60, 32'h7FC00000, "nan pix1");
    checkOutput("nan pix1 key_err", 32'(key_err), 32'd1);
    checkOutput("nan pix1 p_data", 32'(bus.p_data), 32'(sel(8'h90, 8'hE0)));
    applyStimulus(8'h70, 32'h00000000, "nan pix2");
    checkOutput("nan pix2 key_err", 32'(key_err), 32'd1);
    checkOutput("nan pix2 p_data", 32'(bus.p_data), 32'(sel(8'h10, 8'h70)));
    waitFrameDone("nan");
    checkOutput("key_err sticky in idle", 32'(key_err), 32'd1);

    // Zero-length frame clears the error and finishes straight away
    base = out_count;
    bus.c_valid = 1'b1;
    bus.k_valid = 1'b1;
    startFrame(8'h00, 20'd0);
    checkOutput("len0 frame_done", 32'(frame_done), 32'd1);
    checkOutput("len0 key_err cleared", 32'(key_err), 32'd0);
    checkOutput("len0 c_ready", 32'(bus.c_ready), 32'd0);
    @(negedge clk);
    checkOutput("len0 done single", 32'(frame_done), 32'd0);
    checkOutput("len0 busy", 32'(busy), 32'd0);
    checkOutput("len0 no outputs", 32'(out_count - base), 32'd0);
    bus.c_valid = 1'b0;
    bus.k_valid = 1'b0;

    // Reset in the middle of a frame with a pending output and key error
    bus.p_ready = 1'b0;
    startFrame(8'h99, 20'd4);
    applyStimulus(8'h12, 32'h7F800000, "pre-reset");
    checkOutput("pre-reset key_err", 32'(key_err), 32'd1);
    bus.c_valid = 1'b1;
    bus.k_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset p_valid", 32'(bus.p_valid), 32'd0);
    checkOutput("mid reset p_data", 32'(bus.p_data), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset key_err", 32'(key_err), 32'd0);
    checkOutput("mid reset c_ready", 32'(bus.c_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.c_valid = 1'b0;
    bus.k_valid = 1'b0;
    bus.p_ready = 1'b1;
    @(negedge clk);
    startFrame(8'h05, 20'd1);
    applyStimulus(8'h30, 32'h00000000, "post-reset");
    checkOutput("post-reset p_data", 32'(bus.p_data), 32'(sel(8'h2B, 8'h30)));
    waitFrameDone("post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
